// File: rtl/uart_pkg.sv
// uart_pkg: mode and TX state encodings, LED polarity and a width helper for the loopback controller
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO      = 2'b00,
        MODE_ECHO_ALL  = 2'b01,
        MODE_HOLD      = 2'b10,
        MODE_CASE_SWAP = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_BUSY  = 2'b10
    } tx_state_t;

    localparam logic LED_ON = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered storage, wrapping pointers and occupancy count
module uart_sync_fifo import uart_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);
    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign full    = level == (AW + 1)'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end

endmodule

// File: rtl/uart_loopback_ctrl.sv
// uart_loopback_ctrl: buffered uart_rx -> uart_tx bridge with selectable echo modes, error counters and board LEDs
module uart_loopback_ctrl import uart_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int CLK_FREQ    = 27_000_000,
    parameter int HEART_HZ    = 1,
    parameter int STRETCH_CYC = 1_350_000,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  err_clear,
    input  logic                  rx_done,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_parity_err,
    input  logic                  rx_framing_err,
    output logic                  rx_ack,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]      overflow_cnt,
    output logic [CNT_W-1:0]      parity_cnt,
    output logic [CNT_W-1:0]      framing_cnt,
    output logic                  led_heart,
    output logic                  led_rx,
    output logic                  led_tx,
    output logic                  led_err
);
    localparam int HALF = CLK_FREQ / (2 * HEART_HZ);
    localparam int HW   = clog2(HALF);
    localparam int SW   = clog2(STRETCH_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tx_state_t         state, state_nxt;
    logic [1:0]        start_cnt;
    logic              issue, full, empty, rx_err, push, overflow, alpha, err_latch;
    logic [DATA_W-1:0] push_data, head;
    logic [SW-1:0]     rx_cnt, tx_cnt;
    logic [HW-1:0]     heart_cnt;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
        return clr ? CNT_W'(inc) : c + CNT_W'(inc && c != CNT_MAX);
    endfunction

    assign rx_err    = rx_parity_err || rx_framing_err;
    assign push      = rx_done && (mode == MODE_ECHO_ALL || mode == MODE_HOLD || !rx_err);
    assign alpha     = DATA_W == 8 &&
                       ((rx_data >= DATA_W'(8'h41) && rx_data <= DATA_W'(8'h5A)) ||
                        (rx_data >= DATA_W'(8'h61) && rx_data <= DATA_W'(8'h7A)));
    assign push_data = (mode == MODE_CASE_SWAP && alpha) ? rx_data ^ DATA_W'(8'h20) : rx_data;
    assign overflow  = push && full && !issue;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (issue),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    // start_cnt measures cycles since the tx_valid pulse so an ignored start times out
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_IDLE;
            start_cnt <= '0;
        end else begin
            state     <= state_nxt;
            start_cnt <= (state == S_START) ? start_cnt + 2'd1 : 2'd0;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = issue ? S_START : S_IDLE;
            S_START: state_nxt = !tx_ready ? S_BUSY : (start_cnt == 2'd2 ? S_IDLE : S_START);
            S_BUSY:  state_nxt = tx_ready ? S_IDLE : S_BUSY;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb issue = state == S_IDLE && !empty && tx_ready && mode != MODE_HOLD;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_ack       <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            overflow_cnt <= '0;
            parity_cnt   <= '0;
            framing_cnt  <= '0;
            err_latch    <= 1'b0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            heart_cnt    <= '0;
            led_heart    <= 1'b0;
        end else begin
            rx_ack       <= rx_done;
            tx_valid     <= issue;
            if (issue) tx_data <= head;
            overflow_cnt <= cnt_next(overflow_cnt, overflow, err_clear);
            parity_cnt   <= cnt_next(parity_cnt, rx_done && rx_parity_err, err_clear);
            framing_cnt  <= cnt_next(framing_cnt, rx_done && rx_framing_err, err_clear);
            err_latch    <= (err_latch && !err_clear) || (rx_done && rx_err);
            rx_cnt       <= rx_done ? SW'(STRETCH_CYC) : rx_cnt - SW'(rx_cnt != '0);
            tx_cnt       <= tx_valid ? SW'(STRETCH_CYC) : tx_cnt - SW'(tx_cnt != '0);
            heart_cnt    <= (heart_cnt == HW'(HALF - 1)) ? '0 : heart_cnt + HW'(1);
            led_heart    <= led_heart ^ (heart_cnt == HW'(HALF - 1));
        end

    assign led_rx  = (rx_cnt != '0) ? LED_ON : ~LED_ON;
    assign led_tx  = (tx_cnt != '0) ? LED_ON : ~LED_ON;
    assign led_err = err_latch ? LED_ON : ~LED_ON;

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// tb_uart_loopback_ctrl: randomized bench with a queue-based reference model and directed scenarios
module tb_uart_loopback_ctrl;
    localparam int DEPTH = 16, CLK_FREQ = 40, HEART_HZ = 1, S = 5, CW = 4;
    localparam int H = CLK_FREQ / (2 * HEART_HZ);
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 0, rst_n = 1, err_clear = 0, rx_done = 0, rx_parity_err = 0, rx_framing_err = 0, tx_ready = 1;
    logic [1:0] mode = 0;
    logic [7:0] rx_data = 0, tx_data;
    logic       rx_ack, tx_valid, led_heart, led_rx, led_tx, led_err;
    logic [4:0] fifo_level;
    logic [3:0] overflow_cnt, parity_cnt, framing_cnt;

    always #5 clk = ~clk;

    uart_loopback_ctrl #(.DATA_W(8), .DEPTH(DEPTH), .CLK_FREQ(CLK_FREQ), .HEART_HZ(HEART_HZ),
                         .STRETCH_CYC(S), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .err_clear(err_clear), .rx_done(rx_done),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_framing_err(rx_framing_err),
        .rx_ack(rx_ack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .parity_cnt(parity_cnt),
        .framing_cnt(framing_cnt), .led_heart(led_heart), .led_rx(led_rx), .led_tx(led_tx),
        .led_err(led_err)
    );

    int n_chk = 0, n_fail = 0;
    int k = 0, next_ok, lo_from = 1, lo_to = 0, last_rx, last_tx, t;
    int e_ack, e_txv, e_txd, e_ov, e_par, e_fr, e_latch;
    logic [7:0] q[$], dut_sent[$];
    logic       s_rxd = 0, s_pe = 0, s_fe = 0, s_clr = 0;
    logic [1:0] s_mode = 0;
    logic [7:0] s_data = 0;
    logic [7:0] edge_chars [8] = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, k);
        end
    endtask

    function automatic int sat(input int c, input logic inc, input logic clr);
        return clr ? int'(inc) : ((inc && c < CMAX) ? c + 1 : c);
    endfunction

    task automatic model_reset();
        q.delete();
        next_ok = 0; t = 0; last_rx = -1000; last_tx = -1000;
        e_ack = 0; e_txv = 0; e_txd = 0; e_ov = 0; e_par = 0; e_fr = 0; e_latch = 0;
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_rx_ack"}, rx_ack, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
        chk({tag, "_counters"}, {overflow_cnt, parity_cnt, framing_cnt}, 0);
        chk({tag, "_leds"}, {led_heart, led_rx, led_tx, led_err}, 4'b0111);
    endtask

    task automatic compare();
        chk("rx_ack", rx_ack, e_ack);
        chk("tx_valid", tx_valid, e_txv);
        chk("tx_data", tx_data, e_txd);
        chk("fifo_level", fifo_level, q.size());
        chk("overflow_cnt", overflow_cnt, e_ov);
        chk("parity_cnt", parity_cnt, e_par);
        chk("framing_cnt", framing_cnt, e_fr);
        chk("led_err", led_err, e_latch ? 0 : 1);
        chk("led_rx", led_rx, (k - last_rx) <= S ? 0 : 1);
        chk("led_tx", led_tx, (k - last_tx) <= S ? 0 : 1);
        chk("led_heart", led_heart, (t / H) % 2);
        if (tx_valid) dut_sent.push_back(tx_data);
    endtask

    // Compare outputs of the current cycle, drive its inputs, then advance the model to the next cycle
    task automatic cycle();
        logic fl, iss, want, ovf;
        logic [7:0] d;
        int l, p;
        compare();
        tx_ready = !(k >= lo_from && k <= lo_to);
        rx_done = s_rxd; rx_data = s_data; rx_parity_err = s_pe; rx_framing_err = s_fe;
        mode = s_mode; err_clear = s_clr;
        fl  = q.size() == DEPTH;
        iss = k >= next_ok && q.size() != 0 && tx_ready && s_mode != 2'd2;
        if (e_txv != 0) last_tx = k;
        e_txv = int'(iss);
        if (iss) begin
            e_txd = int'(q.pop_front());
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            p = k + 1;
            lo_from = p + 1;
            lo_to = p + l;
            next_ok = (l == 0) ? p + 3 : p + l + 2;
        end
        want = s_rxd && (s_mode == 2'd1 || s_mode == 2'd2 || !(s_pe || s_fe));
        d = s_data;
        if (s_mode == 2'd3 && ((d >= 8'h41 && d <= 8'h5A) || (d >= 8'h61 && d <= 8'h7A))) d = d ^ 8'h20;
        ovf = want && fl && !iss;
        if (want && !ovf) q.push_back(d);
        e_ov = sat(e_ov, ovf, s_clr);
        e_par = sat(e_par, s_rxd && s_pe, s_clr);
        e_fr = sat(e_fr, s_rxd && s_fe, s_clr);
        e_latch = int'((s_rxd && (s_pe || s_fe)) || (e_latch != 0 && !s_clr));
        e_ack = int'(s_rxd);
        if (s_rxd) last_rx = k;
        t++;
        k++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            s_rxd = 0; s_pe = 0; s_fe = 0;
            cycle();
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic fe);
        s_rxd = 1; s_data = d; s_pe = pe; s_fe = fe;
        cycle();
        s_rxd = 0; s_pe = 0; s_fe = 0;
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1 check_reset_literals(tag);
        model_reset();
        rx_done = 0; err_clear = 0; s_rxd = 0; s_clr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 0;
        #2 check_reset_literals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        idle(3);

        // ECHO latency: rx_done at N, rx_ack at N+1, tx_valid at N+2
        s_mode = 2'd0;
        send(8'h55, 0, 0);
        chk("t1_rx_ack", rx_ack, 1);
        chk("t1_level", fifo_level, 1);
        idle(1);
        chk("t1_tx_valid", tx_valid, 1);
        chk("t1_tx_data", tx_data, 8'h55);
        idle(20);
        chk("t1_level_end", fifo_level, 0);

        dut_sent.delete();
        s_mode = 2'd3;
        send(8'h61, 0, 0); send(8'h5A, 0, 0); send(8'h31, 0, 0);
        idle(40);
        chk("t2_count", dut_sent.size(), 3);
        chk("t2_b0", dut_sent.size() > 0 ? int'(dut_sent[0]) : -1, 8'h41);
        chk("t2_b1", dut_sent.size() > 1 ? int'(dut_sent[1]) : -1, 8'h7A);
        chk("t2_b2", dut_sent.size() > 2 ? int'(dut_sent[2]) : -1, 8'h31);

        s_mode = 2'd0; s_clr = 1; idle(1); s_clr = 0;
        s_mode = 2'd2;
        for (int i = 0; i < 20; i++) send(8'(i), 0, 0);
        idle(3);
        chk("t3_level", fifo_level, 16);
        chk("t3_overflow", overflow_cnt, 4);
        dut_sent.delete();
        s_mode = 2'd0;
        idle(150);
        chk("t3_count", dut_sent.size(), 16);
        for (int i = 0; i < 16; i++) chk("t3_order", dut_sent.size() > i ? int'(dut_sent[i]) : -1, i);

        s_clr = 1; idle(1); s_clr = 0;
        dut_sent.delete();
        send(8'hA5, 1, 0);
        chk("t4_parity", parity_cnt, 1);
        chk("t4_led_err", led_err, 0);
        idle(10);
        chk("t4_not_sent", dut_sent.size(), 0);
        s_clr = 1; idle(1); s_clr = 0;
        chk("t4_parity_clr", parity_cnt, 0);
        chk("t4_led_err_clr", led_err, 1);

        for (int i = 0; i < 20; i++) send(8'($urandom), 0, 1);
        chk("t5_framing_sat", framing_cnt, 15);
        s_clr = 1; send(8'h00, 0, 1); s_clr = 0;
        chk("t5_framing_clr_err", framing_cnt, 1);
        chk("t5_led_err", led_err, 0);
        idle(10);

        s_mode = 2'd2;
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 0, 0);
        s_mode = 2'd0;
        for (int i = 0; i < 20 && q.size() != 5; i++) idle(1);
        idle(1);
        chk("t6_level", fifo_level, 5);
        async_reset("t6");
        dut_sent.delete();
        idle(30);
        chk("t6_no_tx", dut_sent.size(), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) s_mode = 2'($urandom_range(0, 3));
            s_clr  = $urandom_range(0, 99) == 0;
            s_rxd  = $urandom_range(0, 2) == 0;
            s_data = ($urandom_range(0, 2) == 0) ? edge_chars[$urandom_range(0, 7)] : 8'($urandom);
            s_pe   = $urandom_range(0, 9) == 0;
            s_fe   = $urandom_range(0, 9) == 0;
            cycle();
            if (i == 1500) async_reset("rand");
        end
        s_clr = 0; s_mode = 2'd0;
        idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
